// File: rtl/prog_sequencer.sv
// Configuration sequencer: serializes a byte stream LSB-first onto the programming chain,
// with an optional verify pass that counts prog_out mismatches against the resent bitstream.
module prog_sequencer #(
    parameter int unsigned CHAIN_LEN   = 96,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       verify,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] mismatch_cnt
);
    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LastBit = CW'(CHAIN_LEN - 1);
    localparam logic [HW-1:0] HpLast  = HW'(HALF_PERIOD - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StShiftLo = 3'd2;
    localparam logic [2:0] StShiftHi = 3'd3;
    localparam logic [2:0] StFinish  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [HW-1:0] hp_cnt_q, hp_cnt_d;
    logic          verify_q, verify_d;
    logic          prog_clk_q, prog_clk_d;
    logic          prog_en_q, prog_en_d;
    logic          prog_in_q, prog_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    mm_q, mm_d;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        bit_idx_d  = bit_idx_q;
        bit_cnt_d  = bit_cnt_q;
        hp_cnt_d   = hp_cnt_q;
        verify_d   = verify_q;
        prog_clk_d = prog_clk_q;
        prog_en_d  = prog_en_q;
        prog_in_d  = prog_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        mm_d       = mm_q;

        case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    verify_d  = verify;
                    mm_d      = 8'd0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    prog_en_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                if (byte_valid) begin
                    byte_d    = byte_in;
                    bit_idx_d = 3'd0;
                    prog_in_d = byte_in[0];
                    hp_cnt_d  = '0;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                if (hp_cnt_q == HpLast) begin
                    if (verify_q && (prog_out != prog_in_q) && (mm_q != 8'hFF)) begin
                        mm_d = mm_q + 8'd1;
                    end
                    hp_cnt_d   = '0;
                    prog_clk_d = 1'b1;
                    state_d    = StShiftHi;
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end
            StShiftHi: begin
                if (hp_cnt_q == HpLast) begin
                    hp_cnt_d   = '0;
                    prog_clk_d = 1'b0;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StFinish;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_idx_q == 3'd7) begin
                            state_d = StFetch;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            prog_in_d = byte_q[bit_idx_q + 3'd1];
                            state_d   = StShiftLo;
                        end
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end
            StFinish: begin
                prog_en_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                if (verify_q) begin
                    error_d = (mm_q != 8'd0);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_q     <= 8'd0;
            bit_idx_q  <= 3'd0;
            bit_cnt_q  <= '0;
            hp_cnt_q   <= '0;
            verify_q   <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mm_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            bit_idx_q  <= bit_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            hp_cnt_q   <= hp_cnt_d;
            verify_q   <= verify_d;
            prog_clk_q <= prog_clk_d;
            prog_en_q  <= prog_en_d;
            prog_in_q  <= prog_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mm_q       <= mm_d;
        end
    end

    assign byte_ready   = (state_q == StFetch);
    assign prog_clk     = prog_clk_q;
    assign prog_en      = prog_en_q;
    assign prog_in      = prog_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign mismatch_cnt = mm_q;

endmodule
